// File: rtl/seq_alu.sv
// Multi-cycle signed ALU with a start/busy/done handshake.
// Add/sub/logic/move/swap finish in one cycle; multiply and divide iterate over WIDTH cycles.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   ALUOp,
  input  logic [WIDTH-1:0] Data1,
  input  logic [WIDTH-1:0] Data2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Upper,
  output logic [WIDTH-1:0] Lower,
  output logic [1:0]       Zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(4'b0100);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(4'b0101);
  localparam logic [OPW-1:0] OP_MOVE = OPW'(4'b0111);
  localparam logic [OPW-1:0] OP_SWAP = OPW'(4'b1000);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4'b1001);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4'b1011);

  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MINUS_ONE = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    SIGN   = 2'd2,
    RESULT = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg_w(v) : v;
  endfunction

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  state_t state, state_nxt;

  logic [OPW-1:0]          op_q;
  logic signed [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0]        hi, lo;
  logic [CNT_W-1:0]        cnt;

  logic                    multi_op;
  logic                    last_iter;
  logic [WIDTH-1:0]        mag_a, mag_b;

  assign multi_op  = (ALUOp == OP_MUL) || (ALUOp == OP_DIV);
  assign last_iter = (cnt == CNT_W'(WIDTH-1));
  assign mag_a     = magnitude(a_q);
  assign mag_b     = magnitude(b_q);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; RESULT may accept a new request directly
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = multi_op ? CALC : RESULT;
      end
      CALC: begin
        if (last_iter) state_nxt = SIGN;
      end
      SIGN: begin
        state_nxt = RESULT;
      end
      RESULT: begin
        if (start) state_nxt = multi_op ? CALC : RESULT;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == CALC) || (state == SIGN);
  end

  // Single-cycle results, computed from the operands present at the accepting edge
  logic signed [WIDTH-1:0] da, db;
  logic signed [WIDTH-1:0] sum_w, diff_w;
  logic [WIDTH-1:0]        fast_hi, fast_lo;
  logic                    fast_exc;

  assign da     = Data1;
  assign db     = Data2;
  assign sum_w  = da + db;
  assign diff_w = da - db;

  always_comb begin
    fast_hi  = '0;
    fast_lo  = '0;
    fast_exc = 1'b0;
    unique case (ALUOp)
      OP_ADD: begin
        fast_lo  = sum_w;
        fast_exc = add_ovf(da[WIDTH-1], db[WIDTH-1], sum_w[WIDTH-1]);
      end
      OP_SUB: begin
        fast_lo  = diff_w;
        fast_exc = sub_ovf(da[WIDTH-1], db[WIDTH-1], diff_w[WIDTH-1]);
      end
      OP_MOVE: fast_lo = Data2;
      OP_SWAP: begin
        fast_lo = Data2;
        fast_hi = Data1;
      end
      OP_AND: fast_lo = Data1 & Data2;
      OP_OR:  fast_lo = Data1 | Data2;
      default: begin
        // Illegal opcode keeps the previous result and only raises the exception flag
        fast_hi  = Upper;
        fast_lo  = Lower;
        fast_exc = 1'b1;
      end
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide on magnitudes
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ge;

  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : '0);
  assign div_shift = {hi, lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b};
  assign div_ge    = (div_shift >= {1'b0, mag_b});

  // Sign correction and special cases applied in SIGN
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi, fin_lo;
  logic               fin_exc;
  logic               res_neg;

  assign res_neg = a_q[WIDTH-1] ^ b_q[WIDTH-1];

  always_comb begin
    prod    = {hi, lo};
    fin_hi  = '0;
    fin_lo  = '0;
    fin_exc = 1'b0;
    if (op_q == OP_MUL) begin
      if (res_neg) prod = neg_2w(prod);
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (b_q == '0) begin
      fin_hi  = a_q;
      fin_lo  = '1;
      fin_exc = 1'b1;
    end else begin
      // MOST_NEG / -1 falls out naturally as quotient magnitude 2^(W-1), which wraps to A
      fin_lo  = res_neg ? neg_w(lo) : lo;
      fin_hi  = a_q[WIDTH-1] ? neg_w(hi) : hi;
      fin_exc = (a_q == MOST_NEG) && (b_q == MINUS_ONE);
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      Upper <= '0;
      Lower <= '0;
      Zero  <= 2'b00;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, RESULT: begin
          if (start) begin
            op_q <= ALUOp;
            a_q  <= Data1;
            b_q  <= Data2;
            cnt  <= '0;
            if (multi_op) begin
              hi <= '0;
              lo <= (ALUOp == OP_DIV) ? magnitude(Data1) : magnitude(Data2);
            end else begin
              Upper <= fast_hi;
              Lower <= fast_lo;
              Zero  <= {fast_exc, (fast_lo == '0)};
              done  <= 1'b1;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q == OP_MUL) begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end else begin
            hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], div_ge};
          end
        end
        SIGN: begin
          Upper <= fin_hi;
          Lower <= fin_lo;
          Zero  <= {fin_exc, (fin_lo == '0)};
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a reference model queues expected results at request time;
// a monitor pops and compares them on every done pulse.
module tb_seq_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   ALUOp = '0;
  logic [W-1:0] Data1 = '0;
  logic [W-1:0] Data2 = '0;
  logic         busy, done;
  logic [W-1:0] Upper, Lower;
  logic [1:0]   Zero;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W), .OPW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUOp(ALUOp),
    .Data1(Data1), .Data2(Data2), .busy(busy), .done(done),
    .Upper(Upper), .Lower(Lower), .Zero(Zero)
  );

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [1:0]   z;
  } exp_t;

  exp_t         sb[$];
  int           n_chk = 0;
  int           n_pass = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model using native signed arithmetic
  task automatic push_exp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int     ai, bi, s;
    longint p;
    exp_t   e;
    logic   exc;
    ai = $signed(a);
    bi = $signed(b);
    exc = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (op)
      4'h0: begin s = ai + bi; e.lo = W'(s); exc = (s > 32767) || (s < -32768); end
      4'h1: begin s = ai - bi; e.lo = W'(s); exc = (s > 32767) || (s < -32768); end
      4'h4: begin p = longint'(ai) * longint'(bi); e.hi = p[31:16]; e.lo = p[15:0]; end
      4'h5: begin
        if (bi == 0) begin e.hi = a; e.lo = '1; exc = 1'b1; end
        else if (ai == -32768 && bi == -1) begin e.lo = a; exc = 1'b1; end
        else begin e.lo = W'(ai / bi); e.hi = W'(ai % bi); end
      end
      4'h7: e.lo = b;
      4'h8: begin e.lo = b; e.hi = a; end
      4'h9: e.lo = a & b;
      4'hB: e.lo = a | b;
      default: begin e.hi = m_hi; e.lo = m_lo; exc = 1'b1; end
    endcase
    e.z = {exc, (e.lo == '0)};
    m_hi = e.hi;
    m_lo = e.lo;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("upper", Upper, e.hi);
        check("lower", Lower, e.lo);
        check("zero", Zero, e.z);
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit b2b, input int exp_lat, input string tag);
    int cyc, nbusy;
    if (!b2b) @(negedge clk);
    ALUOp = op; Data1 = a; Data2 = b; start = 1'b1;
    push_exp(op, a, b);
    cyc = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      ALUOp = 4'($urandom);
      Data1 = W'($urandom);
      Data2 = W'($urandom);
      if (busy === 1'b1) nbusy++;
    end while (done !== 1'b1 && cyc < 40);
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_busy"}, nbusy, (exp_lat == 1) ? 0 : exp_lat - 1);
  endtask

  logic [3:0] ops[9] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hB, 4'h2};

  initial begin
    int cyc, ndone, done_cyc;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_upper", Upper, 0);
    check("rst_lower", Lower, 0);
    check("rst_zero", Zero, 0);
    rst = 1'b1;

    run_op(4'h0, 16'h7FFF, 16'h0001, 0, 1, "add_ovf");
    check("add_lower_k", Lower, 16'h8000);
    check("add_zero_k", Zero, 2'b10);
    run_op(4'h4, 16'hFFFD, 16'h0005, 0, 18, "mul");
    check("mul_prod_k", {Upper, Lower}, 32'hFFFF_FFF1);
    check("mul_zero_k", Zero, 2'b00);
    run_op(4'h5, 16'hFFF9, 16'h0002, 0, 18, "div");
    check("div_k", {Upper, Lower}, 32'hFFFF_FFFD);
    run_op(4'h5, 16'h0005, 16'h0000, 0, 18, "div0");
    check("div0_k", {Upper, Lower, 2'b00}, {16'h0005, 16'hFFFF, 2'b00});
    check("div0_zero_k", Zero, 2'b10);
    run_op(4'h5, 16'h8000, 16'hFFFF, 0, 18, "divmin");
    run_op(4'h1, 16'h8000, 16'h0001, 0, 1, "sub_ovf");
    run_op(4'h1, 16'h1234, 16'h1234, 0, 1, "sub_zero");
    run_op(4'h8, 16'h1234, 16'hABCD, 0, 1, "swap");
    run_op(4'hF, 16'h5555, 16'h6666, 0, 1, "illegal");
    check("illegal_k", {Upper, Lower}, 32'h1234_ABCD);
    check("illegal_zero_k", Zero, 2'b10);

    // Second start during a multiply must be ignored
    @(negedge clk);
    ALUOp = 4'h4; Data1 = 16'h0100; Data2 = 16'hFF00; start = 1'b1;
    push_exp(4'h4, 16'h0100, 16'hFF00);
    cyc = 0; ndone = 0; done_cyc = 0;
    while (cyc < 24) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 4) begin start = 1'b1; ALUOp = 4'h4; Data1 = 16'h0007; Data2 = 16'h0009; end
      if (done === 1'b1) begin ndone++; done_cyc = cyc; end
    end
    check("ign_lat", done_cyc, 18);
    check("ign_ndone", ndone, 1);

    // Back-to-back requests issued in the RESULT cycle
    run_op(4'h0, 16'h0001, 16'h0002, 0, 1, "b2b1");
    run_op(4'h9, 16'hF0F0, 16'hFF00, 1, 1, "b2b2");
    run_op(4'h4, 16'h0003, 16'h0007, 1, 18, "b2b3");
    run_op(4'hB, 16'h00F0, 16'h0F00, 1, 1, "b2b4");

    // Reset in the middle of a divide
    @(negedge clk);
    ALUOp = 4'h5; Data1 = 16'h1234; Data2 = 16'h0003; start = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("rst_mid_busy_before", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_out", {Upper, Lower, Zero}, 34'h0);
    m_hi = '0;
    m_lo = '0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) rst = 1'b1;
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    check("rst_mid_nodone", ndone, 0);
    check("rst_mid_zero", Zero, 2'b00);

    // Random mix through the model
    for (int k = 0; k < 24; k++) begin
      rop = ops[$urandom_range(0, 8)];
      ra  = ($urandom_range(0, 9) == 0) ? 16'h8000 : W'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? 16'h0000 : W'($urandom);
      run_op(rop, ra, rb, bit'($urandom_range(0, 1)), (rop == 4'h4 || rop == 4'h5) ? 18 : 1, "rand");
    end

    repeat (3) @(negedge clk);
    check("pending", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
